// File: rtl/axis_out_framer.sv
// axis_out_framer: re-frames per-line AXI-Stream into SOF/EOF frames for S2MM DMA.
// Optional AXIS_FRAMER_STAT_EN adds stat_frames / stat_err_lines counters.
`timescale 1ns/1ps
module axis_out_framer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int DST_IMG_WIDTH   = 4096,
  parameter int DST_IMG_HEIGHT  = 2160
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         frame_done,
  output logic                         err_len,
  input  logic                         err_clr
`ifdef AXIS_FRAMER_STAT_EN
  ,
  output logic [15:0]                  stat_frames,
  output logic [15:0]                  stat_err_lines
`endif
);

  localparam int DW = AXIS_DATA_WIDTH;
  localparam int W  = DST_IMG_WIDTH;
  localparam int H  = DST_IMG_HEIGHT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_v, skid_v, rdy;
  logic [DW+1:0] out_q, skid_q, in_beat;
  logic          push, pop;
  logic          col_end, beat_first, beat_last;
  logic          line_end, len_bad;
  logic [1:0]    occ_n;

  assign push       = s_axis_tvalid && rdy;
  assign pop        = out_v && m_axis_tready;
  assign col_end    = (col == CW'(W - 1));
  assign beat_first = (col == '0) && (row == '0);
  assign beat_last  = col_end && (row == RW'(H - 1));
  assign line_end   = s_axis_tlast || col_end;
  assign len_bad    = s_axis_tlast != col_end;
  assign in_beat    = {beat_first, beat_last, s_axis_tdata};
  assign occ_n      = 2'(out_v) + 2'(skid_v) + 2'(push) - 2'(pop);

  // frame sequencing: accept a frame, drain it, announce completion
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable && !out_v && !skid_v) state_n = RUN;
      RUN:     if (push && beat_last) state_n = FLUSH;
      FLUSH:   if (pop && out_q[DW]) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // registered ready: open only in RUN with a free slot next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= (state_n == RUN) && (occ_n < 2'd2);
  end

  // two-entry skid buffer; out_q is the registered head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (pop) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= push;
        if (push) skid_q <= in_beat;
      end else begin
        out_v <= push;
        if (push) out_q <= in_beat;
      end
    end else if (push) begin
      if (!out_v) begin
        out_v <= 1'b1;
        out_q <= in_beat;
      end else begin
        skid_v <= 1'b1;
        skid_q <= in_beat;
      end
    end
  end

  // column/row position; bad line lengths still close the line
  always_ff @(posedge clk) begin
    if (!rst_n || state == DONE) begin
      col <= '0;
      row <= '0;
    end else if (push) begin
      if (line_end) begin
        col <= '0;
        row <= (row == RW'(H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // sticky length error; a new error wins over a clear
  always_ff @(posedge clk) begin
    if (!rst_n)              err_len <= 1'b0;
    else if (push && len_bad) err_len <= 1'b1;
    else if (err_clr)         err_len <= 1'b0;
  end

`ifdef AXIS_FRAMER_STAT_EN
  // frame count wraps, error-line count saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames    <= '0;
      stat_err_lines <= '0;
    end else begin
      if (state == DONE) stat_frames <= stat_frames + 16'd1;
      if (push && len_bad && stat_err_lines != 16'hFFFF)
        stat_err_lines <= stat_err_lines + 16'd1;
    end
  end
`endif

  assign s_axis_tready = rdy;
  assign m_axis_tvalid = out_v;
  assign m_axis_tuser  = out_q[DW+1];
  assign m_axis_tlast  = out_q[DW];
  assign m_axis_tdata  = out_q[DW-1:0];
  assign m_axis_tkeep  = '1;
  assign frame_done    = (state == DONE);

endmodule

// File: tb/tb_axis_out_framer.sv
// tb_axis_out_framer: scoreboard bench for axis_out_framer, W=4 H=2.
// Define AXIS_FRAMER_STAT_EN to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_axis_out_framer;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          frame_done;
  logic          err_len;
  logic          err_clr = 1'b0;
`ifdef AXIS_FRAMER_STAT_EN
  logic [15:0]   stat_frames;
  logic [15:0]   stat_err_lines;
`endif

  always #5 clk = ~clk;

  axis_out_framer #(
    .AXIS_DATA_WIDTH(DW),
    .DST_IMG_WIDTH(W),
    .DST_IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .frame_done(frame_done),
    .err_len(err_len),
    .err_clr(err_clr)
`ifdef AXIS_FRAMER_STAT_EN
    ,
    .stat_frames(stat_frames),
    .stat_err_lines(stat_err_lines)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_tl = -100;
  int mcol = 0;
  int mrow = 0;
  logic merr = 1'b0;
  logic tog = 1'b0;
  logic stall_p = 1'b0;
  logic [DW+1:0] prev_beat = '0;
  logic [DW+1:0] cur;
  logic [DW+1:0] q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void mpush(input logic [DW-1:0] d, input logic l);
    logic fu, fl;
    fu = (mcol == 0) && (mrow == 0);
    fl = (mcol == W - 1) && (mrow == H - 1);
    if ((l && mcol != W - 1) || (mcol == W - 1 && !l)) merr = 1'b1;
    q.push_back({fu, fl, d});
    if (l || mcol == W - 1) begin
      mcol = 0;
      mrow = fl ? 0 : (mrow + 1) % H;
    end else begin
      mcol++;
    end
  endfunction

  // monitor: scoreboard pop, stall stability, frame_done timing
  initial forever begin
    @(negedge clk);
    cyc++;
    cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst_n) begin
      if (stall_p && m_axis_tvalid) check("stable", cur, prev_beat);
      if (stall_p) check("stall_valid", m_axis_tvalid, 1);
      if (frame_done) begin
        done_cnt++;
        check("done_lat", cyc - last_tl, 1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) check("beat", cur, q.pop_front());
        if (m_axis_tlast) last_tl = cyc;
      end
      stall_p   = m_axis_tvalid && !m_axis_tready;
      prev_beat = cur;
    end else begin
      stall_p = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog) m_axis_tready = !m_axis_tready;
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        mpush(d, l);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("s_handshake", ok, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    err_clr = 1'b0;
    tog = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {s_axis_tready, m_axis_tvalid, m_axis_tuser,
                         m_axis_tlast, frame_done, err_len, m_axis_tdata}, 0);
    q.delete();
    mcol = 0;
    mrow = 0;
    merr = 1'b0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic finish_frame(input int exp_done);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    check("done_cnt", done_cnt, exp_done);
    check("err_len", err_len, merr);
  endtask

  task automatic send_line(input int base, input int n, input logic tl);
    for (int i = 0; i < n; i++)
      send(DW'(base + i), tl && (i == n - 1));
  endtask

  initial begin
    // 1: clean frame, full-rate sink
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_no_ready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    send_line(0, 4, 1'b1);
    send_line(4, 4, 1'b1);
    finish_frame(1);

    // 2: stalled then toggling sink
    do_reset();
    m_axis_tready = 1'b0;
    enable = 1'b1;
    send(0, 1'b0);
    send(1, 1'b0);
    @(negedge clk);
    check("s_ready_full", s_axis_tready, 0);
    check("m_valid_held", m_axis_tvalid, 1);
    @(posedge clk);
    #1;
    tog = 1'b1;
    send(2, 1'b0);
    send(3, 1'b1);
    send_line(4, 4, 1'b1);
    finish_frame(1);
    tog = 1'b0;
    m_axis_tready = 1'b1;

    // 3: early tlast on the first line, then a following frame
    do_reset();
    enable = 1'b1;
    send_line(0, 3, 1'b1);
    send_line(3, 4, 1'b1);
    finish_frame(1);
    check("t3_err", err_len, 1);
    send_line(7, 4, 1'b1);
    send_line(11, 4, 1'b1);
    finish_frame(2);

    // 4: missing tlast on the first line, then clear
    do_reset();
    enable = 1'b1;
    send_line(0, 4, 1'b0);
    send_line(4, 4, 1'b1);
    finish_frame(1);
    check("t4_err", err_len, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    merr = 1'b0;
    @(negedge clk);
    check("err_clr", err_len, 0);

    // 5: reset in the middle of a frame
    do_reset();
    enable = 1'b1;
    send_line(0, 4, 1'b1);
    send_line(4, 2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outs", {s_axis_tready, m_axis_tvalid, m_axis_tuser,
                            m_axis_tlast, frame_done, err_len,
                            m_axis_tdata}, 0);
    q.delete();
    mcol = 0;
    mrow = 0;
    merr = 1'b0;
    check("no_done_aborted", done_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_line(100, 4, 1'b1);
    send_line(104, 4, 1'b1);
    finish_frame(1);

`ifdef AXIS_FRAMER_STAT_EN
    // 6: statistics over four frames, one with a short line
    do_reset();
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_line(f * 8, 4, 1'b1);
      send_line(f * 8 + 4, 4, 1'b1);
      finish_frame(f + 1);
    end
    send_line(50, 3, 1'b1);
    send_line(53, 4, 1'b1);
    finish_frame(4);
    check("stat_frames", stat_frames, 4);
    check("stat_err_lines", stat_err_lines, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
